// File: rtl/xswitch_pkg.sv
// Shared switch definitions: arbiter state encoding and one-hot to binary conversion.
package xswitch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // OR-reduction form: returns 0 for an all-zero vector, valid for up to 16 lines.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r = r | 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/xarb_rr_pick.sv
// Combinational circular first-one picker: first set req bit at or above ptr, wrapping.
module xarb_rr_pick
  import xswitch_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx
);

  logic found;
  int   j;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        win[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign win_idx = $clog2(N)'(onehot_to_idx(16'(win)));

endmodule

// File: rtl/xarb_burst_sched.sv
// Burst-locking round-robin arbiter with optional per-requester burst quota.
// Define XARB_WEIGHT_EN to enable the weighted quota (otherwise plain burst round-robin).
module xarb_burst_sched
  import xswitch_pkg::*;
#(
  parameter int N  = 4,
  parameter int QW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         last,
  input  logic                 ready,
  input  logic [N*QW-1:0]      quota,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [IW-1:0] w_q, w_d, p_q, p_d, next_idx;
  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          last_acc, rotate;

  xarb_rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (p_q),
    .win     (pick_oh),
    .win_idx (pick_idx)
  );

  assign last_acc = (state_q == BUSY) && req[w_q] && ready && last[w_q];
  assign next_idx = (w_q == IW'(N - 1)) ? '0 : w_q + 1'b1;

`ifdef XARB_WEIGHT_EN
  logic [QW-1:0] c_q, c_d, q_raw, q_eff;

  // A zero quota field still grants one burst per turn.
  assign q_raw  = quota[int'(w_q)*QW +: QW];
  assign q_eff  = (q_raw == '0) ? QW'(1) : q_raw;
  assign rotate = ({1'b0, c_q} + 1'b1) >= {1'b0, q_eff};
  assign c_d    = last_acc ? (rotate ? '0 : c_q + 1'b1) : c_q;

  always_ff @(posedge clk) begin
    if (rst) c_q <= '0;
    else     c_q <= c_d;
  end
`else
  logic quota_unused;
  assign quota_unused = ^quota;
  assign rotate       = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          w_d     = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_acc) begin
          state_d = IDLE;
          p_d     = rotate ? next_idx : w_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      p_q     <= p_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign gnt     = busy ? ({{(N-1){1'b0}}, 1'b1} << w_q) : '0;
  assign gnt_idx = busy ? w_q : '0;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_stable:  assert property (@(posedge clk) disable iff (rst)
                                  (busy && !last_acc) |=> $stable(gnt));

endmodule

// File: tb/tb_xarb_burst_sched.sv
// Directed table-driven bench for xarb_burst_sched (N=4, QW=4).
module tb_xarb_burst_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, last;
  logic        ready;
  logic [15:0] quota;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        busy;

  int errors = 0;
  int checks = 0;

  xarb_burst_sched #(.N(4), .QW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .ready   (ready),
    .quota   (quota),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                     input logic rd, input logic [3:0] g, input logic [1:0] ix,
                     input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.ready = rd;
    v.gnt = g; v.idx = ix; v.busy = b;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, and compare outputs 1 time unit later.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                      input logic rd);
    rst = r; req = rq; last = ls; ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic r, input logic [3:0] rq,
                          input logic [3:0] ls, input logic rd, input logic [3:0] g,
                          input logic [1:0] ix, input logic b);
    step(r, rq, ls, rd);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ix));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    int nseen;
    logic [1:0] seen[8];
    logic [1:0] want[8];

    rst = 1'b1; req = '0; last = '0; ready = 1'b0; quota = '0;
    #2;

    // reset with everyone requesting, then plain round-robin
    add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h1, 0, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h2, 1, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h4, 2, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h8, 3, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h1, 0, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h2, 1, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h4, 2, 1);
    // requester 2 burst of 3 beats, ready 1,0,1,1
    add(0, 4'hF, 4'h0, 1, 4'h4, 2, 1);
    add(0, 4'hF, 4'h0, 0, 4'h4, 2, 1);
    add(0, 4'hF, 4'h0, 1, 4'h4, 2, 1);
    add(0, 4'hF, 4'h4, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h8, 3, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h1, 0, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h2, 1, 1);
    // owner 1 drops req for two cycles while others flag last
    add(0, 4'hD, 4'hF, 1, 4'h2, 1, 1);
    add(0, 4'hD, 4'hF, 1, 4'h2, 1, 1);
    add(0, 4'hF, 4'h0, 1, 4'h2, 1, 1);
    add(0, 4'hF, 4'h2, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'h4, 2, 1);
    add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    // idle with no requests, then wrap search from pointer 3 to requester 0
    add(0, 4'h0, 4'h0, 1, 4'h0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 0, 0);
    add(0, 4'h1, 4'h1, 1, 4'h1, 0, 1);
    add(0, 4'h1, 4'h1, 1, 4'h0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      step_chk($sformatf("vec%0d", i), tv[i].rst, tv[i].req, tv[i].last,
               tv[i].ready, tv[i].gnt, tv[i].idx, tv[i].busy);
    end

    // reset while requester 3 owns a burst; next grant goes to lowest requester
    step_chk("rstmid.own", 0, 4'h8, 4'h0, 1, 4'h8, 3, 1);
    step_chk("rstmid.own2", 0, 4'hF, 4'h0, 0, 4'h8, 3, 1);
    step_chk("rstmid.rst", 1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    step_chk("rstmid.after", 0, 4'hA, 4'h0, 0, 4'h2, 1, 1);
    step_chk("rstmid.hold", 0, 4'hA, 4'h0, 0, 4'h2, 1, 1);

    // quota {1,0,3,2}: weighted order, or plain rotation when the quota is ignored
    step(1, 4'h0, 4'h0, 0);
    quota = 16'h1032;
`ifdef XARB_WEIGHT_EN
    want = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`endif
    nseen = 0;
    for (int c = 0; c < 40 && nseen < 8; c++) begin
      step(0, 4'hF, 4'hF, 1);
      if (busy) begin
        seen[nseen] = gnt_idx;
        nseen++;
      end
    end
    chk("quota.count", 32'(nseen), 32'd8);
    for (int k = 0; k < nseen; k++) begin
      chk($sformatf("quota.order%0d", k), 32'(seen[k]), 32'(want[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/xarb_burst_sched.md
XARB_BURST_SCHED -- requirements
Module: xarb_burst_sched

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter QW, default 4: width of each per-requester quota field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N  per-requester beat valid; bit i means requester i has a beat to send.
REQ-006 last  input  N  per-requester end-of-burst flag; meaningful only with the matching req bit.
REQ-007 ready  input  1  shared target accepts the current beat.
REQ-008 quota  input  N*QW  per-requester burst quota; field i is bits [i*QW +: QW]; ignored unless XARB_WEIGHT_EN is defined.
REQ-009 gnt  output  N  one-hot grant, or all zero.
REQ-010 gnt_idx  output  $clog2(N)  binary index of the granted requester; 0 when gnt is zero.
REQ-011 busy  output  1  high while in the BUSY state.

Function
REQ-012 The block SHALL have two states, IDLE and BUSY, plus internal state: owner index W, rotation pointer P and burst counter C.
REQ-013 IDLE: gnt is zero; when req is nonzero, the winner is the first set req bit searching circularly from P upward; the block SHALL register it as W and go to BUSY.
REQ-014 Grant latency SHALL be exactly 1 cycle: req seen in IDLE at cycle t gives gnt at cycle t+1.
REQ-015 BUSY: gnt SHALL equal onehot(W) every cycle, busy SHALL be 1, and gnt_idx SHALL equal W.
REQ-016 A beat SHALL be accepted when req[W] and ready are both high; any other req bit has no effect while in BUSY.
REQ-017 If req[W] drops mid-burst, the lock SHALL hold; gnt stays on W until a beat with last[W] is accepted.
REQ-018 When a beat with last[W] is accepted, the block SHALL increment C and return to IDLE on the next cycle, which gives one gnt-zero bubble between bursts.
REQ-019 At that burst end, if C+1 reaches the effective quota, P SHALL become (W+1) mod N and C SHALL clear; otherwise P SHALL become W so that W keeps priority.
REQ-020 Wrap-around: with W = N-1, the rotation SHALL set P to 0.
REQ-021 Starvation bound: a continuously requesting requester SHALL be granted within (N-1) times maxquota bursts.
REQ-022 gnt SHALL never have more than one bit set, and gnt SHALL be zero in IDLE.

Reset
REQ-023 While rst is high on a clock edge: state becomes IDLE, and W, P and C become 0.
REQ-024 From the cycle after that edge, gnt=0, gnt_idx=0 and busy=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further grant.
REQ-026 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-027 With XARB_WEIGHT_EN defined, the effective quota for requester i SHALL be quota field i, with a value of 0 treated as 1, and C SHALL be QW bits wide.
REQ-028 Without XARB_WEIGHT_EN, the effective quota SHALL be 1 (plain burst round-robin), C and its logic SHALL be absent, and the quota port SHALL remain but be unused.

Structure
REQ-029 A shared package xswitch_pkg SHALL hold the state enum (IDLE, BUSY) and a function that converts a one-hot vector to a binary index.
REQ-030 One sub-module SHALL exist: xarb_rr_pick, a combinational circular first-one picker taking req and P and returning a one-hot winner and its index; it is reused by other switch arbiters.
REQ-031 Non-synthesis assertions SHALL check: gnt is one-hot or zero; gnt is stable while busy and no last beat has been accepted.

Verification (N=4, QW=4)
REQ-032 Reset: rst high for 2 cycles with req=4'b1111 -> gnt=0, busy=0 during reset; gnt=4'b0001 on the second cycle after rst falls.
REQ-033 Round-robin: req=4'b1111 held, ready=1, last=4'b1111, macro off -> gnt sequence 0001,0,0010,0,0100,0,1000,0,0001.
REQ-034 Lock: requester 2 runs a 3-beat burst with ready toggling 1,0,1,1 and req=4'b1111 -> gnt stays 0100 until the third accepted beat, which carries last.
REQ-035 Req drop: owner 1 drops req for 2 cycles mid-burst -> gnt stays 0010, no beat is accepted, other requesters are not granted.
REQ-036 Weighted (macro on, quota={4'd1,4'd0,4'd3,4'd2}, field 3 down to 0): all requesting single-beat bursts -> grant order 0,0,1,1,1,2,3,0.
REQ-037 Reset mid-burst: rst pulses while gnt=1000 -> gnt=0 on the next cycle; after reset, the next grant goes to the lowest active requester.
